// File: rtl/num_classifier_seq_if.sv
// Handshake bundle for num_classifier_seq: request, result flags and totals.
interface num_classifier_seq_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] num;
  logic             out_valid;
  logic             out_ready;
  logic             is_zero;
  logic             is_even;
  logic             is_div3;
  logic             is_pow2;
  logic             is_prime;
  logic [CNT_W-1:0] prime_cnt;
  logic [CNT_W-1:0] total_cnt;
  logic             clr_cnt;

  modport master (
    output in_valid, num, out_ready, clr_cnt,
    input  in_ready, out_valid,
    input  is_zero, is_even, is_div3, is_pow2, is_prime,
    input  prime_cnt, total_cnt
  );

  modport slave (
    input  in_valid, num, out_ready, clr_cnt,
    output in_ready, out_valid,
    output is_zero, is_even, is_div3, is_pow2, is_prime,
    output prime_cnt, total_cnt
  );
endinterface

// File: rtl/num_classifier_seq.sv
// Sequential number classifier with trial-division primality FSM
// and saturating result totals.
module num_classifier_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  num_classifier_seq_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [WIDTH-1:0] TWO = WIDTH'(2);
  localparam logic [WIDTH-1:0] THREE = WIDTH'(3);

  state_t           state, state_nx;
  logic [WIDTH-1:0] n, n_nx;
  logic [WIDTH-1:0] d, d_nx;
  logic             done_now;
  logic             prime_res;
  logic [2*WIDTH-1:0] sq;
  logic             consume;

  logic             f_zero, f_even, f_div3;
  logic             f_pow2, f_prime;
  logic [CNT_W-1:0] prime_cnt, total_cnt;

  // Full-width square so d*d never overflows.
  assign sq = {{WIDTH{1'b0}}, d} * {{WIDTH{1'b0}}, d};

  always_comb begin
    state_nx  = state;
    n_nx      = n;
    d_nx      = d;
    done_now  = 1'b0;
    prime_res = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          n_nx     = bus.num;
          d_nx     = TWO;
          state_nx = CHECK;
        end
      end
      CHECK: begin
        if (n < TWO) begin
          done_now = 1'b1;
        end else if (sq > {{WIDTH{1'b0}}, n}) begin
          done_now  = 1'b1;
          prime_res = 1'b1;
        end else if ((n % d) == '0) begin
          done_now = 1'b1;
        end else begin
          d_nx = d + 1'b1;
        end
        if (done_now) state_nx = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign consume = (state == DONE) && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      n         <= '0;
      d         <= '0;
      f_zero    <= 1'b0;
      f_even    <= 1'b0;
      f_div3    <= 1'b0;
      f_pow2    <= 1'b0;
      f_prime   <= 1'b0;
      prime_cnt <= '0;
      total_cnt <= '0;
    end else begin
      state <= state_nx;
      n     <= n_nx;
      d     <= d_nx;
      if (done_now) begin
        f_zero  <= (n == '0);
        f_even  <= ~n[0];
        f_div3  <= ((n % THREE) == '0);
        f_pow2  <= (n != '0) && ((n & (n - 1'b1)) == '0);
        f_prime <= prime_res;
      end
      // Clear takes priority over a same-cycle consume.
      if (bus.clr_cnt) begin
        prime_cnt <= '0;
        total_cnt <= '0;
      end else if (consume) begin
        if (total_cnt != CMAX) total_cnt <= total_cnt + 1'b1;
        if (f_prime && prime_cnt != CMAX) prime_cnt <= prime_cnt + 1'b1;
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.is_zero   = f_zero;
  assign bus.is_even   = f_even;
  assign bus.is_div3   = f_div3;
  assign bus.is_pow2   = f_pow2;
  assign bus.is_prime  = f_prime;
  assign bus.prime_cnt = prime_cnt;
  assign bus.total_cnt = total_cnt;
endmodule

// File: tb/tb_num_classifier_seq.sv
// Directed bench for num_classifier_seq: WIDTH=8/CNT_W=8 main instance
// plus a CNT_W=2 instance for counter saturation.
module tb_num_classifier_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  num_classifier_seq_if #(.WIDTH(8), .CNT_W(8)) a ();
  num_classifier_seq_if #(.WIDTH(8), .CNT_W(2)) b ();

  num_classifier_seq #(.WIDTH(8), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (a.slave)
  );

  num_classifier_seq #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (b.slave)
  );

  // {zero, even, div3, pow2, prime}
  function automatic logic [4:0] flags_a();
    return {a.is_zero, a.is_even, a.is_div3, a.is_pow2, a.is_prime};
  endfunction

  task automatic send_a(input logic [7:0] v);
    a.in_valid = 1'b1;
    a.num      = v;
    @(posedge clk); #1;
    a.in_valid = 1'b0;
    a.num      = 8'hA5;
  endtask

  // Edges from accept until out_valid; -1 if the bound expires.
  task automatic wait_a(output int k);
    k = 0;
    while (!a.out_valid && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    if (!a.out_valid) k = -1;
  endtask

  task automatic consume_a();
    a.out_ready = 1'b1;
    @(posedge clk); #1;
    a.out_ready = 1'b0;
  endtask

  task automatic clear_a();
    a.clr_cnt = 1'b1;
    @(posedge clk); #1;
    a.clr_cnt = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (a.in_ready !== 1'b1 || a.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: ready=%b valid=%b want 1 0",
               a.in_ready, a.out_valid);
    end
    checks++;
    if (flags_a() !== 5'b00000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000", flags_a());
    end
    checks++;
    if (a.prime_cnt !== 8'd0 || a.total_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d/%0d want 0/0",
               a.prime_cnt, a.total_cnt);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_zero();
    int k;
    send_a(8'd0);
    wait_a(k);
    checks++;
    if (k !== 1) begin
      errors++;
      $display("FAIL zero_latency: got %0d want 1", k);
    end
    checks++;
    if (flags_a() !== 5'b11100) begin
      errors++;
      $display("FAIL zero_flags: got %b want 11100", flags_a());
    end
    consume_a();
  endtask

  task automatic test_hold();
    int k;
    clear_a();
    send_a(8'd7);
    wait_a(k);
    checks++;
    if (k !== 2) begin
      errors++;
      $display("FAIL seven_latency: got %0d want 2", k);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (a.out_valid !== 1'b1 || flags_a() !== 5'b00001) begin
        errors++;
        $display("FAIL seven_hold%0d: valid=%b flags=%b want 1 00001",
                 i, a.out_valid, flags_a());
      end
      a.num = 8'(i * 2);
      a.in_valid = 1'b1;
      @(posedge clk); #1;
      a.in_valid = 1'b0;
    end
    consume_a();
    checks++;
    if (a.prime_cnt !== 8'd1 || a.total_cnt !== 8'd1
        || a.in_ready !== 1'b1 || a.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL seven_consume: cnt=%0d/%0d rdy=%b vld=%b want 1/1 1 0",
               a.prime_cnt, a.total_cnt, a.in_ready, a.out_valid);
    end
  endtask

  task automatic test_large();
    logic [7:0] nums [3] = '{8'd251, 8'd255, 8'd128};
    int         lat  [3] = '{15, 2, 1};
    logic [4:0] fl   [3] = '{5'b00001, 5'b00100, 5'b01010};
    int k;
    for (int i = 0; i < 3; i++) begin
      send_a(nums[i]);
      wait_a(k);
      checks++;
      if (k !== lat[i] || flags_a() !== fl[i]) begin
        errors++;
        $display("FAIL large_%0d: k=%0d flags=%b want k=%0d flags=%b",
                 nums[i], k, flags_a(), lat[i], fl[i]);
      end
      consume_a();
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] fl [10] = '{5'b00010, 5'b01011, 5'b00101, 5'b01010,
                            5'b00001, 5'b01100, 5'b00001, 5'b01010,
                            5'b00100, 5'b01000};
    int k;
    clear_a();
    for (int v = 1; v <= 10; v++) begin
      send_a(8'(v));
      wait_a(k);
      checks++;
      if (k < 1 || flags_a() !== fl[v-1]) begin
        errors++;
        $display("FAIL sweep_%0d: k=%0d flags=%b want %b",
                 v, k, flags_a(), fl[v-1]);
      end
      consume_a();
    end
    checks++;
    if (a.prime_cnt !== 8'd4 || a.total_cnt !== 8'd10) begin
      errors++;
      $display("FAIL sweep_cnt: got %0d/%0d want 4/10",
               a.prime_cnt, a.total_cnt);
    end
  endtask

  task automatic test_reset_abort();
    int k;
    send_a(8'd251);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (a.out_valid !== 1'b0 || a.in_ready !== 1'b1
        || a.prime_cnt !== 8'd0 || a.total_cnt !== 8'd0) begin
      errors++;
      $display("FAIL abort: vld=%b rdy=%b cnt=%0d/%0d want 0 1 0/0",
               a.out_valid, a.in_ready, a.prime_cnt, a.total_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send_a(8'd3);
    wait_a(k);
    checks++;
    if (k !== 1 || flags_a() !== 5'b00101) begin
      errors++;
      $display("FAIL after_abort: k=%0d flags=%b want 1 00101",
               k, flags_a());
    end
    consume_a();
    checks++;
    if (a.prime_cnt !== 8'd1 || a.total_cnt !== 8'd1) begin
      errors++;
      $display("FAIL after_abort_cnt: got %0d/%0d want 1/1",
               a.prime_cnt, a.total_cnt);
    end
  endtask

  task automatic test_saturate();
    int k;
    logic [1:0] want;
    for (int i = 0; i < 6; i++) begin
      b.in_valid = 1'b1;
      b.num      = 8'd7;
      @(posedge clk); #1;
      b.in_valid = 1'b0;
      k = 0;
      while (!b.out_valid && k < 50) begin
        @(posedge clk); #1;
        k++;
      end
      checks++;
      if (b.out_valid !== 1'b1 || b.is_prime !== 1'b1) begin
        errors++;
        $display("FAIL sat_result%0d: vld=%b prime=%b want 1 1",
                 i, b.out_valid, b.is_prime);
      end
      b.out_ready = 1'b1;
      b.clr_cnt   = (i == 5);
      @(posedge clk); #1;
      b.out_ready = 1'b0;
      b.clr_cnt   = 1'b0;
      want = (i == 5) ? 2'd0 : ((i >= 2) ? 2'd3 : 2'(i + 1));
      checks++;
      if (b.prime_cnt !== want || b.total_cnt !== want) begin
        errors++;
        $display("FAIL sat_cnt%0d: got %0d/%0d want %0d/%0d",
                 i, b.prime_cnt, b.total_cnt, want, want);
      end
    end
  endtask

  initial begin
    a.in_valid  = 1'b0;
    a.num       = '0;
    a.out_ready = 1'b0;
    a.clr_cnt   = 1'b0;
    b.in_valid  = 1'b0;
    b.num       = '0;
    b.out_ready = 1'b0;
    b.clr_cnt   = 1'b0;
    test_reset();
    test_zero();
    test_hold();
    test_large();
    test_back_to_back();
    test_reset_abort();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
